// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for a four-digit 7-segment display.
// One digit slot at a time: a short blanking gap, then the digit's pattern.
// All four digit patterns are captured together at frame start so that a
// display never mixes values from two different counter states.
module seg7_scan #(
  parameter int DPN = 256,          // clocks per digit slot
  parameter int BLN = 16,           // blanking clocks at slot start
  parameter int BKL = 6,            // blink frame counter width
  parameter int DPL = $clog2(DPN)   // slot counter width
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] dig_0,
  input  logic [6:0] dig_1,
  input  logic [6:0] dig_2,
  input  logic [6:0] dig_3,
  input  logic       blink,
  input  logic       lzb,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frm
);

  localparam logic [DPL-1:0] CNT_LAST = DPL'(DPN - 1);
  localparam logic [DPL-1:0] CNT_BLN  = DPL'(BLN);

  logic [DPL-1:0]  cnt;
  logic [1:0]      idx;
  logic [BKL-1:0]  fcnt;
  logic [3:0][6:0] lat;
  logic [3:0][6:0] dig;

  logic frame_start, slot_end, on_ph, blink_hide, lzb_hide, vis;
  logic [6:0] seg_d;
  logic [3:0] an_d;

  assign dig         = {dig_3, dig_2, dig_1, dig_0};
  assign slot_end    = (cnt == CNT_LAST);
  assign frame_start = (idx == 2'd0) && (cnt == '0);
  assign on_ph       = (cnt >= CNT_BLN);
  // Dark half of the blink period is the frame counter MSB.
  assign blink_hide  = blink && fcnt[BKL-1];
  // Only the leftmost digit is a leading digit; a '0' there is suppressed.
  assign lzb_hide    = (idx == 2'd3) && lzb && (lat[3] == 7'h3F);
  assign vis         = on_ph && !blink_hide && !lzb_hide;

  // Slot counter and digit index: cnt wraps each slot, idx advances per slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= idx + 2'd1;
    end
  end

  // Coherent digit capture: all four latches load together at frame start.
  always_ff @(posedge clk) begin
    if (rst)              lat <= '0;
    else if (frame_start) lat <= dig;
  end

  // Blink frame counter: parked at zero while blink is off so that enabling
  // blink always begins in the visible half.
  always_ff @(posedge clk) begin
    if (rst || !blink)    fcnt <= '0;
    else if (frame_start) fcnt <= fcnt + 1'b1;
  end

  // Decode of the current state into the next registered pin values.
  always_comb begin
    an_d  = 4'b0000;
    seg_d = 7'h00;
    if (vis) begin
      an_d  = 4'b0001 << idx;
      seg_d = lat[idx];
    end
  end

  // Output registers; blanked to zero on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= 7'h00;
      an  <= 4'b0000;
      frm <= 1'b0;
    end else begin
      seg <= seg_d;
      an  <= an_d;
      frm <= frame_start;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed bench for seg7_scan with DPN=8, BLN=2, BKL=2.
// Edge k is the k-th rising edge with rst low; outputs sampled 1 time unit
// after each edge. Frame f (from 1) spans edges 32(f-1)+1 .. 32f.
module tb_seg7_scan;

  localparam int DPN = 8;
  localparam int BLN = 2;
  localparam int BKL = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] dig_0, dig_1, dig_2, dig_3;
  logic       blink, lzb;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frm;

  int checks = 0;
  int errors = 0;
  int k = 0;

  seg7_scan #(.DPN(DPN), .BLN(BLN), .BKL(BKL)) dut (
    .clk(clk), .rst(rst),
    .dig_0(dig_0), .dig_1(dig_1), .dig_2(dig_2), .dig_3(dig_3),
    .blink(blink), .lzb(lzb),
    .seg(seg), .an(an), .frm(frm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst) k++;
  endtask

  // Expected enable from edge number: slot = (k-1)/DPN, blank for first BLN edges.
  function automatic logic [3:0] scan_an(input int kk);
    int c, s;
    c = (kk - 1) % DPN;
    s = ((kk - 1) / DPN) % 4;
    return (c >= BLN) ? (4'b0001 << s) : 4'b0000;
  endfunction

  function automatic int slot_of(input int kk);
    return ((kk - 1) / DPN) % 4;
  endfunction

  logic [6:0] tbl1 [4];
  logic [6:0] tbl2 [4];
  logic [6:0] tbl3 [4];
  logic [3:0] ea;
  logic [6:0] es;
  int f;

  initial begin
    tbl1[0] = 7'h3F; tbl1[1] = 7'h06; tbl1[2] = 7'h5B; tbl1[3] = 7'h4F;
    tbl2[0] = 7'h3F; tbl2[1] = 7'h7F; tbl2[2] = 7'h5B; tbl2[3] = 7'h4F;
    tbl3[0] = 7'h3F; tbl3[1] = 7'h7F; tbl3[2] = 7'h3F; tbl3[3] = 7'h3F;

    rst = 1'b1; blink = 1'b0; lzb = 1'b0;
    dig_0 = 7'h3F; dig_1 = 7'h06; dig_2 = 7'h5B; dig_3 = 7'h4F;
    repeat (3) step();
    chk("rst_seg", seg, 0);
    chk("rst_an", an, 0);
    chk("rst_frm", frm, 0);
    rst = 1'b0;

    // Frames 1-2: scan timing, plus a mid-frame dig_1 change before edge 12.
    for (int i = 1; i <= 64; i++) begin
      if (i == 12) dig_1 = 7'h7F;
      step();
      ea = scan_an(k);
      es = (ea == 0) ? 7'h00 : ((k <= 32) ? tbl1[slot_of(k)] : tbl2[slot_of(k)]);
      chk("scan_an", an, ea);
      chk("scan_seg", seg, es);
      chk("scan_frm", frm, (k == 1 || k == 33));
    end

    // Frame 3: leading-zero blanking of digit 3; digit 2 '0' still shown.
    dig_2 = 7'h3F; dig_3 = 7'h3F; lzb = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      chk("lzb_no_d3", an == 4'b1000, 0);
      if (k == 83) begin
        chk("lzb_d2_an", an, 4'b0100);
        chk("lzb_d2_seg", seg, 7'h3F);
      end
    end
    // Frame 4: lzb off restores digit 3.
    lzb = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (k == 99)  chk("nolzb_d0_seg", seg, 7'h3F);
      if (k == 123) begin
        chk("nolzb_d3_an", an, 4'b1000);
        chk("nolzb_d3_seg", seg, 7'h3F);
      end
    end

    // Frames 5-11: blink enabled after edge 129, dropped before edge 331.
    step();
    blink = 1'b1;
    while (k < 352) begin
      if (k == 330) blink = 1'b0;
      step();
      f = (k - 1) / 32 + 1;
      if (f == 7 || f == 8 || (f == 11 && k < 331)) ea = 4'b0000;
      else ea = scan_an(k);
      es = (ea == 0) ? 7'h00 : tbl3[slot_of(k)];
      chk("blink_an", an, ea);
      chk("blink_seg", seg, es);
    end

    // Reset mid-scan while digit 0 is lit.
    repeat (3) step();
    chk("pre_rst_an", an, 4'b0001);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_seg", seg, 0);
      chk("midrst_an", an, 0);
      chk("midrst_frm", frm, 0);
    end
    rst = 1'b0;
    k = 0;
    step();
    chk("rel_frm1", frm, 1);
    chk("rel_an1", an, 0);
    step();
    chk("rel_frm2", frm, 0);
    step();
    chk("rel_an3", an, 4'b0001);
    chk("rel_seg3", seg, 7'h3F);

    // Random stimulus: enable stays zero/one-hot, segments dark when no enable.
    for (int i = 0; i < 10000; i++) begin
      dig_0 = 7'($urandom); dig_1 = 7'($urandom);
      dig_2 = 7'($urandom); dig_3 = 7'($urandom);
      if ($urandom_range(0, 99) == 0) blink = ~blink;
      if ($urandom_range(0, 99) == 0) lzb = ~lzb;
      step();
      chk("onehot", $onehot0(an), 1);
      chk("seg_dark", (an == 0) && (seg != 0), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
